// File: rtl/frac_pkg.sv
// Shared types and helpers for the fractal escape-time engine: one-hot state
// encodings, fixed-point format derivation, escape limit and saturation test.
package frac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_MULT   = 3'b010,
        ST_UPDATE = 3'b100
    } state_e;

    // Wide enough to hold any 2N-bit product for N up to 64.
    localparam int WIDE_W = 128;

    function automatic int frac_bits(input int n, input int m);
        return n - m;
    endfunction

    function automatic logic [WIDE_W-1:0] esc_limit(input int r2, input int f);
        logic [WIDE_W-1:0] lim;
        lim = WIDE_W'(r2);
        return lim << f;
    endfunction

    // Returns {above max, below min} for an N-bit signed destination.
    function automatic logic [1:0] sat_ovf(input logic signed [WIDE_W-1:0] v, input int n);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (WIDE_W'(1) <<< (n - 1)) - WIDE_W'(1);
        lo = -hi - WIDE_W'(1);
        return {(v > hi), (v < lo)};
    endfunction

endpackage

// File: rtl/frac_escape_core_mult.sv
// Signed NxN -> 2N multiplier with LAT register stages; stages advance only
// while ce is high so a result stays put once the iteration leaves MULT.
module frac_mult_pipe #(
    parameter int N   = 32,
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic signed [N-1:0]   a,
    input  logic signed [N-1:0]   b,
    output logic signed [2*N-1:0] p
);

    logic signed [2*N-1:0] stage_q [LAT];
    logic signed [2*N-1:0] stage_d [LAT];

    always_comb begin
        stage_d = stage_q;
        if (ce) begin
            stage_d[0] = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
            for (int i = 1; i < LAT; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // NOTE: the stage array is a handful of registers, not a RAM, so it takes the
    // reset like any flop; all state updates here use <= to avoid update-order races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign p = stage_q[LAT-1];

endmodule

// File: rtl/frac_escape_core.sv
// Escape-time iterator z <= z^2 + c in signed Q(M).(N-M), Mandelbrot or Julia,
// with a pipelined multiplier, programmable escape radius and abort.
module frac_escape_core
    import frac_pkg::*;
#(
    parameter int N        = 32,
    parameter int M        = 4,
    parameter int MULT_LAT = 2,
    parameter int ITER_W   = 16,
    parameter int ESC_R2   = 4
) (
    input  logic              frac_clk,
    input  logic              frac_rst_n,
    input  logic              frac_go,
    input  logic              frac_abort,
    input  logic              frac_mode,
    input  logic [N-1:0]      frac_px,
    input  logic [N-1:0]      frac_py,
    input  logic [N-1:0]      frac_jcx,
    input  logic [N-1:0]      frac_jcy,
    input  logic [ITER_W-1:0] frac_max_iter,
    output logic              frac_busy,
    output logic              frac_done_tick,
    output logic              frac_found,
    output logic [ITER_W-1:0] frac_iter_cnt
);

    localparam int                    F        = frac_bits(N, M);
    localparam logic [WIDE_W-1:0]     ESC_WIDE = esc_limit(ESC_R2, F);
    localparam logic [N:0]            ESC_LIM  = ESC_WIDE[N:0];
    localparam int                    LAT_W    = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [LAT_W-1:0]      LAT_LOAD = LAT_W'(MULT_LAT - 1);
    localparam logic signed [N-1:0]   SAT_MAX  = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0]   SAT_MIN  = {1'b1, {(N-1){1'b0}}};

    state_e                state_q, state_d;
    logic signed [N-1:0]   x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [ITER_W-1:0]     cnt_q, cnt_d, max_q, max_d, cnt_inc;
    logic                  busy_q, busy_d, done_q, done_d, found_q, found_d;

    logic                  mult_ce;
    logic signed [2*N-1:0] xx_p, yy_p, xy_p;
    logic signed [2*N-1:0] xx_s, yy_s, xy_s;
    logic signed [N-1:0]   x2, y2, xy2;
    logic [N:0]            mag2;
    logic                  esc;

    function automatic logic signed [N-1:0] sat_n(input logic signed [2*N-1:0] v);
        logic [1:0] ovf;
        ovf = sat_ovf(WIDE_W'(v), N);
        if (ovf[1]) return SAT_MAX;
        if (ovf[0]) return SAT_MIN;
        return v[N-1:0];
    endfunction

    assign mult_ce = (state_q == ST_MULT);

    frac_mult_pipe #(.N(N), .LAT(MULT_LAT)) u_mult_xx (
        .clk(frac_clk), .rst_n(frac_rst_n), .ce(mult_ce), .a(x_q), .b(x_q), .p(xx_p)
    );
    frac_mult_pipe #(.N(N), .LAT(MULT_LAT)) u_mult_yy (
        .clk(frac_clk), .rst_n(frac_rst_n), .ce(mult_ce), .a(y_q), .b(y_q), .p(yy_p)
    );
    frac_mult_pipe #(.N(N), .LAT(MULT_LAT)) u_mult_xy (
        .clk(frac_clk), .rst_n(frac_rst_n), .ce(mult_ce), .a(x_q), .b(y_q), .p(xy_p)
    );

    // Shifting xy by one less than F folds in the factor of two of 2xy.
    always_comb begin
        xx_s = xx_p >>> F;
        yy_s = yy_p >>> F;
        xy_s = xy_p >>> (F - 1);
        x2   = sat_n(xx_s);
        y2   = sat_n(yy_s);
        xy2  = sat_n(xy_s);
        mag2 = {1'b0, x2} + {1'b0, y2};
        esc  = mag2 > ESC_LIM;
    end

    assign cnt_inc = cnt_q + ITER_W'(1);

    // NOTE: every output of this block is given its hold value first, so no
    // path through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        busy_d  = busy_q;
        found_d = found_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (frac_go) begin
                    x_d     = frac_px;
                    y_d     = frac_py;
                    cx_d    = frac_mode ? frac_jcx : frac_px;
                    cy_d    = frac_mode ? frac_jcy : frac_py;
                    max_d   = frac_max_iter;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    if (frac_max_iter == '0) begin
                        found_d = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_MULT;
                        busy_d  = 1'b1;
                        lat_d   = LAT_LOAD;
                    end
                end
            end
            ST_MULT: begin
                if (lat_q == '0) begin
                    state_d = ST_UPDATE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_UPDATE: begin
                if (esc) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    found_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    x_d   = x2 - y2 + cx_q;
                    y_d   = xy2 + cy_q;
                    if (cnt_inc == max_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        found_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_MULT;
                        lat_d   = LAT_LOAD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides everything, including a terminating UPDATE.
        if (frac_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            found_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge frac_clk) begin
        if (!frac_rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            lat_q   <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            found_q <= found_d;
        end
    end

    assign frac_busy      = busy_q;
    assign frac_done_tick = done_q;
    assign frac_found     = found_q;
    assign frac_iter_cnt  = cnt_q;

endmodule

// File: tb/tb_frac_escape_core.sv
// Directed bench for frac_escape_core: a table of pixels with hand-computed
// latency/found/count, plus go-while-busy, abort, idle-abort and mid-run reset.
module tb_frac_escape_core;

    localparam int N        = 32;
    localparam int M        = 4;
    localparam int MULT_LAT = 2;
    localparam int ITER_W   = 16;
    localparam int ESC_R2   = 4;
    localparam int NVEC     = 11;
    localparam int BOUND    = 1000;

    localparam logic [N-1:0] Q_ZERO = 32'h0000_0000;
    localparam logic [N-1:0] Q_HALF = 32'h0800_0000;
    localparam logic [N-1:0] Q_ONE  = 32'h1000_0000;
    localparam logic [N-1:0] Q_TWO  = 32'h2000_0000;
    localparam logic [N-1:0] Q_THR  = 32'h3000_0000;
    localparam logic [N-1:0] Q_M1   = 32'hF000_0000;
    localparam logic [N-1:0] Q_M2   = 32'hE000_0000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              go, abort, mode;
    logic [N-1:0]      px, py, jcx, jcy;
    logic [ITER_W-1:0] max_iter;
    logic              busy, done_tick, found;
    logic [ITER_W-1:0] iter_cnt;

    always #5 clk = ~clk;

    frac_escape_core #(
        .N(N), .M(M), .MULT_LAT(MULT_LAT), .ITER_W(ITER_W), .ESC_R2(ESC_R2)
    ) dut (
        .frac_clk(clk),
        .frac_rst_n(rst_n),
        .frac_go(go),
        .frac_abort(abort),
        .frac_mode(mode),
        .frac_px(px),
        .frac_py(py),
        .frac_jcx(jcx),
        .frac_jcy(jcy),
        .frac_max_iter(max_iter),
        .frac_busy(busy),
        .frac_done_tick(done_tick),
        .frac_found(found),
        .frac_iter_cnt(iter_cnt)
    );

    typedef struct {
        logic              mode;
        logic [N-1:0]      px;
        logic [N-1:0]      py;
        logic [N-1:0]      jcx;
        logic [N-1:0]      jcy;
        logic [ITER_W-1:0] max_iter;
        int                exp_lat;
        logic              exp_found;
        logic [ITER_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs [NVEC];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; go is sampled on the next posedge (the accept edge).
    task automatic start_pixel(input vec_t v);
        mode     = v.mode;
        px       = v.px;
        py       = v.py;
        jcx      = v.jcx;
        jcy      = v.jcy;
        max_iter = v.max_iter;
        go       = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    // Returns the cycle index (after the accept edge) where done_tick is seen,
    // or -1 if it never arrives within the bound. Leaves time at that negedge.
    task automatic run_pixel(input vec_t v, output int lat, output logic busy_ok);
        start_pixel(v);
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= BOUND; k++) begin
            @(negedge clk);
            if (done_tick) begin
                lat = k;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic saw_done;

        vecs[0]  = '{1'b0, Q_ZERO, Q_ZERO, Q_TWO,  Q_ZERO, 16'd16,  49,  1'b1, 16'd16};
        vecs[1]  = '{1'b0, Q_TWO,  Q_ZERO, Q_ZERO, Q_ZERO, 16'd100, 7,   1'b0, 16'd1};
        vecs[2]  = '{1'b0, Q_THR,  Q_ZERO, Q_ZERO, Q_ZERO, 16'd100, 4,   1'b0, 16'd0};
        vecs[3]  = '{1'b1, Q_HALF, Q_ZERO, Q_ZERO, Q_ZERO, 16'd8,   25,  1'b1, 16'd8};
        vecs[4]  = '{1'b1, Q_HALF, Q_ZERO, Q_ZERO, Q_ZERO, 16'd0,   1,   1'b1, 16'd0};
        vecs[5]  = '{1'b0, Q_M2,   Q_ZERO, Q_ZERO, Q_ZERO, 16'd50,  151, 1'b1, 16'd50};
        vecs[6]  = '{1'b0, Q_M1,   Q_ZERO, Q_ZERO, Q_ZERO, 16'd5,   16,  1'b1, 16'd5};
        vecs[7]  = '{1'b0, Q_ZERO, Q_ONE,  Q_ZERO, Q_ZERO, 16'd7,   22,  1'b1, 16'd7};
        vecs[8]  = '{1'b1, Q_ZERO, Q_ZERO, Q_TWO,  Q_ZERO, 16'd100, 10,  1'b0, 16'd2};
        vecs[9]  = '{1'b0, Q_ZERO, Q_ZERO, Q_ZERO, Q_ZERO, 16'd1,   4,   1'b1, 16'd1};
        vecs[10] = '{1'b0, Q_ONE,  Q_ONE,  Q_ZERO, Q_ZERO, 16'd100, 7,   1'b0, 16'd1};

        rst_n    = 1'b0;
        go       = 1'b0;
        abort    = 1'b0;
        mode     = 1'b0;
        px       = '0;
        py       = '0;
        jcx      = '0;
        jcy      = '0;
        max_iter = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy",  64'(busy),      64'd0);
        check("reset_done",  64'(done_tick), 64'd0);
        check("reset_found", 64'(found),     64'd0);
        check("reset_cnt",   64'(iter_cnt),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: each new go lands in the previous pixel's done cycle.
        for (int i = 0; i < NVEC; i++) begin
            run_pixel(vecs[i], lat, busy_ok);
            check($sformatf("vec%0d_lat", i),   64'(lat),      64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_found", i), 64'(found),    64'(vecs[i].exp_found));
            check($sformatf("vec%0d_cnt", i),   64'(iter_cnt), 64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_busy", i),  64'(busy_ok),  64'd1);
        end

        // done_tick is a single-cycle pulse; results hold afterwards.
        @(negedge clk);
        check("pulse_done",  64'(done_tick), 64'd0);
        check("pulse_found", 64'(found),     64'd0);
        check("pulse_cnt",   64'(iter_cnt),  64'd1);

        // go re-pulsed while busy is ignored; abort drops to IDLE silently.
        start_pixel(vecs[0]);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            go = 1'b0;
            if (k == 10) begin
                px       = Q_THR;
                max_iter = 16'd1;
                go       = 1'b1;
            end
            if (k == 11) begin
                check("go_busy_busy", 64'(busy),     64'd1);
                check("go_busy_cnt",  64'(iter_cnt), 64'd3);
            end
            if (k == 20) begin
                check("abort_pre_cnt", 64'(iter_cnt), 64'd6);
                abort = 1'b1;
            end
        end
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy",  64'(busy),      64'd0);
        check("abort_done",  64'(done_tick), 64'd0);
        check("abort_found", 64'(found),     64'd0);
        check("abort_cnt",   64'(iter_cnt),  64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_tick || busy) saw_done = 1'b1;
        end
        check("abort_quiet", 64'(saw_done), 64'd0);

        // Synchronous reset in the middle of a pixel, then a clean rerun.
        start_pixel(vecs[0]);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy",  64'(busy),      64'd0);
        check("midrst_done",  64'(done_tick), 64'd0);
        check("midrst_found", 64'(found),     64'd0);
        check("midrst_cnt",   64'(iter_cnt),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_pixel(vecs[0], lat, busy_ok);
        check("rerun_lat",   64'(lat),      64'd49);
        check("rerun_found", 64'(found),    64'd1);
        check("rerun_cnt",   64'(iter_cnt), 64'd16);

        // Abort while IDLE (here: the done cycle) leaves results untouched.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_found", 64'(found),     64'd1);
        check("idle_abort_cnt",   64'(iter_cnt),  64'd16);
        check("idle_abort_busy",  64'(busy),      64'd0);
        check("idle_abort_done",  64'(done_tick), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frac_escape_core.md
Name: frac_escape_core

Overview:
Parametrised successor to the single-mode fractal iteration engine. Iterates z(k+1) = z(k)^2 + c in signed fixed point Q(M).(N-M). Supports Mandelbrot and Julia modes, a configurable multiplier pipeline depth and a programmable escape radius. Reports the escape iteration count, a found flag, and supports abort. Sits between the pixel scheduler and the colour-map / frame-buffer writer.

Parameters:
N, 32, total fixed-point width (signed), N >= 8
M, 4, integer bits incl. sign; F = N-M fractional bits, F >= 2
MULT_LAT, 2, multiplier register stages, >= 1
ITER_W, 16, width of iteration limit and count
ESC_R2, 4, escape threshold on |z|^2 (integer); limit = ESC_R2 << F, must be < 2^(N-1)

Ports:
frac_clk  in  1  clock
frac_rst_n  in  1  synchronous active-low reset
frac_go  in  1  start pulse; accepted only in IDLE
frac_abort  in  1  abandon current pixel, return to IDLE, no done_tick
frac_mode  in  1  0 = Mandelbrot (z0=c=pixel), 1 = Julia (z0=pixel, c=julia const)
frac_px  in  N  pixel real part
frac_py  in  N  pixel imaginary part
frac_jcx  in  N  Julia constant real part
frac_jcy  in  N  Julia constant imaginary part
frac_max_iter  in  ITER_W  iteration limit
frac_busy  out  1  high from go acceptance until return to IDLE
frac_done_tick  out  1  one-cycle pulse when result is valid
frac_found  out  1  1 = limit reached without escape; held until next accepted go
frac_iter_cnt  out  ITER_W  non-escaping UPDATEs completed; held until next accepted go

Behaviour:
- Reset (frac_rst_n=0 at clock edge): all outputs 0, state IDLE, pipeline enables 0. Applies mid-operation too; the pixel is discarded.
- All inputs are sampled only on the go-accept edge; later changes are ignored.
- States (one-hot, frac_pkg encodings): IDLE, MULT, UPDATE.
- IDLE + frac_go:
  - Latch x=px, y=py; c=(px,py) if mode=0, else (jcx,jcy).
  - Clear cnt and found; busy<=1.
  - If max_iter==0: done_tick next cycle, found=1, cnt=0, stay IDLE.
  - Else go to MULT with the multiplier enable asserted.
- MULT: hold for exactly MULT_LAT cycles (down-counter), then UPDATE.
- UPDATE (one cycle):
  - x2 = sat(x*x >>> F); y2 = sat(y*y >>> F); xy2 = sat(x*y >>> (F-1)).
  - sat clamps to [-2^(N-1), 2^(N-1)-1]; the shifted product is truncated, not rounded.
  - esc = ({1'b0,x2} + {1'b0,y2}) > (ESC_R2 << F), compared at N+1 bits.
  - If esc: done, found=0, cnt unchanged.
  - Else cnt<=cnt+1; x<=x2-y2+cx; y<=xy2+cy (N-bit wrap).
  - If cnt+1==max_iter: done, found=1.
  - Otherwise return to MULT.
- Done: done_tick pulses the cycle after the terminating UPDATE; busy falls the same cycle; state IDLE.
- Latency: for K UPDATE visits, done_tick at T0 + K*(MULT_LAT+1) + 1, where T0 is the go-accept edge.
- frac_go while busy: ignored; no effect on state or outputs.
- frac_abort while busy: IDLE next cycle, busy=0, no done_tick, found/cnt cleared.
  - Abort wins over a coincident terminating UPDATE.
  - Abort in IDLE: no effect.
- A new go may be accepted in the cycle done_tick is high (state is IDLE).

Decomposition:
- frac_pkg: state encodings, F derivation, ESC limit function, sat() helper.
- Sub-module frac_mult_pipe: signed NxN -> 2N multiplier, MULT_LAT stages, ce input; instantiated three times (xx, yy, xy).

Test Plan:
Defaults (N=32, M=4, MULT_LAT=2), mode 0.
1. px=py=0, max_iter=16 -> done_tick at T0+49, found=1, cnt=16, busy high T0+1..T0+48.
2. px=0x2000_0000 (2.0), py=0, max_iter=100 -> 1st UPDATE |z|^2=4 not escape, 2nd 36 escape -> done at T0+7, found=0, cnt=1.
3. px=0x3000_0000 (3.0), max_iter=100 -> x2 saturates to 0x7FFF_FFFF, escape on 1st UPDATE, done at T0+4, cnt=0, found=0.
4. mode=1, jc=(0,0), px=0x0800_0000 (0.5), max_iter=8 -> found=1, cnt=8; repeat with max_iter=0 -> done at T0+1, found=1, cnt=0.
5. Case 1 with frac_go re-pulsed at T0+10 and frac_abort at T0+20 -> go ignored, busy=0 at T0+21, no done_tick, found=cnt=0.
6. frac_rst_n low at T0+15 of case 1 -> all outputs 0 next edge; new go after release completes normally (done at T0'+49).
